// File: rtl/multicycle_core_sequencer.sv
//------------------------------------------------------------------------------
// multicycle_core_sequencer
//
// Multi-cycle control sequencer for the core. It walks the existing
// fetch/decode/execute/memory/writeback datapath through one instruction at a
// time. It owns the PC and the instruction register, and it drives the stage
// enables into the datapath. Both memories use a req/ready handshake, so any
// memory latency is tolerated.
//
// State sequence:
//   RST_IDLE -> IF -> ID -> EX -> [MEM] -> WB -> IF ...
//   ID or EX may divert to TRAP. TRAP is terminal; only reset leaves it.
//
// Optional feature:
//   PERF_COUNTERS_EN - when defined, cycle_cnt and instret_cnt are real
//                      wrapping counters. When undefined, both outputs are
//                      tied to zero and no counter flops exist.
//
// Parameters:
//   XLEN     - datapath/PC width (32 or 64)
//   RESET_PC - PC loaded on reset (word aligned)
//   CNT_W    - performance counter width
//
// Ports:
//   clk, rst_n                  - clock, asynchronous active-low reset
//   imem_req/addr/ready/rdata   - instruction fetch handshake
//   ir, pc                      - instruction register and program counter
//   branch_taken/target         - execute-stage branch outcome (valid in EX)
//   mem_read/mem_write          - decoded memory op (valid from ID onward)
//   reg_write                   - decoded register write (valid from ID onward)
//   illegal_instr               - decode fault flag (valid in ID)
//   dmem_req/ready              - data memory handshake
//   id_en, ex_en, wb_en         - stage enables / register-file write strobe
//   retire                      - one-cycle pulse per completed instruction
//   trap, trap_cause            - sticky trap flag and cause
//                                 (1 = illegal, 2 = misaligned target)
//   cycle_cnt, instret_cnt      - performance counters
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module multicycle_core_sequencer #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [XLEN-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      ir,
    output logic [XLEN-1:0]  pc,
    input  logic             branch_taken,
    input  logic [XLEN-1:0]  branch_target,
    input  logic             mem_read,
    input  logic             mem_write,
    input  logic             reg_write,
    input  logic             illegal_instr,
    output logic             dmem_req,
    input  logic             dmem_ready,
    output logic             id_en,
    output logic             ex_en,
    output logic             wb_en,
    output logic             retire,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    typedef enum logic [2:0] {
        ST_RST_IDLE = 3'd0,
        ST_IF       = 3'd1,
        ST_ID       = 3'd2,
        ST_EX       = 3'd3,
        ST_MEM      = 3'd4,
        ST_WB       = 3'd5,
        ST_TRAP     = 3'd6
    } state_e;

    localparam logic [31:0] NOP_INSTR      = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE     = 2'd0;
    localparam logic [1:0]  CAUSE_ILLEGAL  = 2'd1;
    localparam logic [1:0]  CAUSE_MISALIGN = 2'd2;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [31:0]       ir_q, ir_d;
    logic              br_taken_q, br_taken_d;
    logic [XLEN-1:0]   br_target_q, br_target_d;
    logic              imem_req_q, imem_req_d;
    logic              dmem_req_q, dmem_req_d;
    logic              id_en_q, id_en_d;
    logic              ex_en_q, ex_en_d;
    logic              wb_en_q, wb_en_d;
    logic              retire_q, retire_d;
    logic              trap_q, trap_d;
    logic [1:0]        trap_cause_q, trap_cause_d;

    // Next-state and datapath-register updates.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        br_taken_d   = br_taken_q;
        br_target_d  = br_target_q;
        trap_cause_d = trap_cause_q;

        case (state_q)
            ST_RST_IDLE: begin
                state_d = ST_IF;
            end
            ST_IF: begin
                // The address is held steady from pc_q until the memory
                // signals completion.
                if (imem_ready) begin
                    ir_d    = imem_rdata;
                    state_d = ST_ID;
                end
            end
            ST_ID: begin
                if (illegal_instr) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_ILLEGAL;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                // Branch outcome is only valid in EX. Keep it until WB,
                // where the PC is finally updated.
                br_taken_d  = branch_taken;
                br_target_d = branch_target;
                if (branch_taken && (branch_target[1:0] != 2'b00)) begin
                    state_d      = ST_TRAP;
                    trap_cause_d = CAUSE_MISALIGN;
                end else if (mem_read || mem_write) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                pc_d    = br_taken_q ? br_target_q : (pc_q + XLEN'(4));
                state_d = ST_IF;
            end
            ST_TRAP: begin
                state_d = ST_TRAP;
            end
            default: begin
                state_d = ST_RST_IDLE;
            end
        endcase

        // Outputs are registered. Derive each one from the state being
        // entered, so it is asserted for exactly the cycles spent in that
        // state.
        imem_req_d = (state_d == ST_IF);
        dmem_req_d = (state_d == ST_MEM);
        id_en_d    = (state_d == ST_ID);
        ex_en_d    = (state_d == ST_EX);
        retire_d   = (state_d == ST_WB);
        wb_en_d    = (state_d == ST_WB) && reg_write;
        trap_d     = (state_d == ST_TRAP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RST_IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= NOP_INSTR;
            br_taken_q   <= 1'b0;
            br_target_q  <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            id_en_q      <= 1'b0;
            ex_en_q      <= 1'b0;
            wb_en_q      <= 1'b0;
            retire_q     <= 1'b0;
            trap_q       <= 1'b0;
            trap_cause_q <= CAUSE_NONE;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            br_taken_q   <= br_taken_d;
            br_target_q  <= br_target_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            id_en_q      <= id_en_d;
            ex_en_q      <= ex_en_d;
            wb_en_q      <= wb_en_d;
            retire_q     <= retire_d;
            trap_q       <= trap_d;
            trap_cause_q <= trap_cause_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign ir         = ir_q;
    assign dmem_req   = dmem_req_q;
    assign id_en      = id_en_q;
    assign ex_en      = ex_en_q;
    assign wb_en      = wb_en_q;
    assign retire     = retire_q;
    assign trap       = trap_q;
    assign trap_cause = trap_cause_q;

`ifdef PERF_COUNTERS_EN
    logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
    logic [CNT_W-1:0] instret_cnt_q, instret_cnt_d;

    // The cycle count includes the RST_IDLE cycle and freezes once trapped.
    // instret follows the registered retire pulse, so it steps at the end
    // of WB.
    always_comb begin
        cycle_cnt_d   = cycle_cnt_q;
        instret_cnt_d = instret_cnt_q;
        if (state_q != ST_TRAP) begin
            cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
        end
        if (retire_q) begin
            instret_cnt_d = instret_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_q   <= '0;
            instret_cnt_q <= '0;
        end else begin
            cycle_cnt_q   <= cycle_cnt_d;
            instret_cnt_q <= instret_cnt_d;
        end
    end

    assign cycle_cnt   = cycle_cnt_q;
    assign instret_cnt = instret_cnt_q;
`else
    assign cycle_cnt   = '0;
    assign instret_cnt = '0;
`endif

endmodule
